// File: rtl/ram_port_arbiter_if.sv
// ram_port_arbiter_if: bundle of the two requester ports (IFU = m0, LSU = m1)
// and the single-port SRAM port driven by ram_port_arbiter.
// The 'slave' modport is the arbiter's view; 'master' is the view of the
// environment that owns the requesters and the RAM.
interface ram_port_arbiter_if #(
  parameter int AW = 32,
  parameter int DW = 32,
  parameter int MW = 4
);
  // IFU port (read-only)
  logic          m0_req;
  logic [AW-1:0] m0_addr;
  logic          m0_gnt;
  logic          m0_rvalid;
  logic [DW-1:0] m0_rdata;
  // LSU port (read/write, with lock)
  logic          m1_req;
  logic          m1_we;
  logic [MW-1:0] m1_wem;
  logic [AW-1:0] m1_addr;
  logic [DW-1:0] m1_wdata;
  logic          m1_lock;
  logic          m1_gnt;
  logic          m1_rvalid;
  logic [DW-1:0] m1_rdata;
  // shared SRAM port
  logic          ram_cs;
  logic          ram_we;
  logic [MW-1:0] ram_wem;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_din;
  logic [DW-1:0] ram_dout;

  modport slave (
    input  m0_req, m0_addr,
    output m0_gnt, m0_rvalid, m0_rdata,
    input  m1_req, m1_we, m1_wem, m1_addr, m1_wdata, m1_lock,
    output m1_gnt, m1_rvalid, m1_rdata,
    output ram_cs, ram_we, ram_wem, ram_addr, ram_din,
    input  ram_dout
  );

  modport master (
    output m0_req, m0_addr,
    input  m0_gnt, m0_rvalid, m0_rdata,
    output m1_req, m1_we, m1_wem, m1_addr, m1_wdata, m1_lock,
    input  m1_gnt, m1_rvalid, m1_rdata,
    input  ram_cs, ram_we, ram_wem, ram_addr, ram_din,
    output ram_dout
  );
endinterface

// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter: shares one single-port SRAM between the IFU (m0, reads
// only) and the LSU (m1, reads/writes). One RAM access per cycle, registered
// read data, and an LSU lock for back-to-back (read-modify-write) accesses.
//
// Optional feature macro: ARB_ROUND_ROBIN_EN
//   defined   -> conflicts in ARB go to the master not granted last
//   undefined -> fixed priority, m1 wins every conflict
//
// Handshake: a master holds req/addr/data stable while req=1; the access
// happens on the rising edge where gnt=1 (gnt is combinational from req and
// state). For reads, rvalid is 1 for exactly the cycle after that edge and
// rdata holds until the next read for the same master completes.
module ram_port_arbiter #(
  parameter int AW = 32,
  parameter int DW = 32,
  parameter int MW = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  ram_port_arbiter_if.slave   bus,
  output logic                dbg_lock,
  output logic                dbg_last_m1
);

  typedef enum logic {
    ST_ARB  = 1'b0,
    ST_LOCK = 1'b1
  } state_t;

  state_t        state_q, state_d;
  logic          last_m1_q;
  logic          m0_gnt_c, m1_gnt_c;
  logic          m1_wins_conflict;
  logic          m0_rvalid_q, m1_rvalid_q;
  logic [DW-1:0] m0_rdata_q, m1_rdata_q;

`ifdef ARB_ROUND_ROBIN_EN
  assign m1_wins_conflict = ~last_m1_q;
`else
  assign m1_wins_conflict = 1'b1;
`endif

  // Grant selection and lock state transitions
  always_comb begin
    state_d  = state_q;
    m0_gnt_c = 1'b0;
    m1_gnt_c = 1'b0;
    case (state_q)
      ST_ARB: begin
        if (bus.m0_req && bus.m1_req) begin
          m1_gnt_c = m1_wins_conflict;
          m0_gnt_c = ~m1_wins_conflict;
        end else begin
          m0_gnt_c = bus.m0_req;
          m1_gnt_c = bus.m1_req;
        end
        if (m1_gnt_c && bus.m1_lock) state_d = ST_LOCK;
      end
      ST_LOCK: begin
        // m1 owns the RAM; leave on an idle cycle or an unlocked access
        m1_gnt_c = bus.m1_req;
        if (!bus.m1_req || !bus.m1_lock) state_d = ST_ARB;
      end
      default: state_d = ST_ARB;
    endcase
  end

  // RAM port mux: granted master drives the RAM, everything zero otherwise
  always_comb begin
    bus.ram_cs   = 1'b0;
    bus.ram_we   = 1'b0;
    bus.ram_wem  = '0;
    bus.ram_addr = '0;
    bus.ram_din  = '0;
    if (m1_gnt_c) begin
      bus.ram_cs   = 1'b1;
      bus.ram_we   = bus.m1_we;
      bus.ram_wem  = bus.m1_wem & {MW{bus.m1_we}};
      bus.ram_addr = bus.m1_addr;
      bus.ram_din  = bus.m1_wdata;
    end else if (m0_gnt_c) begin
      bus.ram_cs   = 1'b1;
      bus.ram_addr = bus.m0_addr;
    end
  end

  // State register and last-grant pointer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_ARB;
      last_m1_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (m1_gnt_c) begin
        last_m1_q <= 1'b1;
      end else if (m0_gnt_c) begin
        last_m1_q <= 1'b0;
      end
    end
  end

  // Read response registers: capture RAM data on the granting edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m0_rvalid_q <= 1'b0;
      m1_rvalid_q <= 1'b0;
      m0_rdata_q  <= '0;
      m1_rdata_q  <= '0;
    end else begin
      m0_rvalid_q <= m0_gnt_c;
      m1_rvalid_q <= m1_gnt_c & ~bus.m1_we;
      if (m0_gnt_c) m0_rdata_q <= bus.ram_dout;
      if (m1_gnt_c && !bus.m1_we) m1_rdata_q <= bus.ram_dout;
    end
  end

  assign bus.m0_gnt    = m0_gnt_c;
  assign bus.m1_gnt    = m1_gnt_c;
  assign bus.m0_rvalid = m0_rvalid_q;
  assign bus.m1_rvalid = m1_rvalid_q;
  assign bus.m0_rdata  = m0_rdata_q;
  assign bus.m1_rdata  = m1_rdata_q;
  assign dbg_lock      = (state_q == ST_LOCK);
  assign dbg_last_m1   = last_m1_q;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// tb_ram_port_arbiter: directed steps followed by random traffic, checked
// against a transaction-level model (ownership flag, last-winner flag, a
// shadow memory and per-master expected read-data queues).
module tb_ram_port_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int MW = 4;
`ifdef ARB_ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  ram_port_arbiter_if #(.AW(AW), .DW(DW), .MW(MW)) bus ();
  logic dbg_lock, dbg_last_m1;

  ram_port_arbiter #(.AW(AW), .DW(DW), .MW(MW)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus),
    .dbg_lock    (dbg_lock),
    .dbg_last_m1 (dbg_last_m1)
  );

  // ---------------- RAM environment (16 words) ----------------
  logic [DW-1:0] ram_mem [16];
  assign bus.ram_dout = ram_mem[bus.ram_addr[5:2]];
  always @(posedge clk) begin
    if (bus.ram_cs && bus.ram_we) begin
      for (int b = 0; b < MW; b++)
        if (bus.ram_wem[b]) ram_mem[bus.ram_addr[5:2]][8*b +: 8] <= bus.ram_din[8*b +: 8];
    end
  end

  // ---------------- reference model ----------------
  int n_cmp = 0;
  int n_bad = 0;
  logic [DW-1:0] ref_mem [16];
  logic [DW-1:0] exp_q0[$];
  logic [DW-1:0] exp_q1[$];
  bit            m_owned;      // LSU currently holds the RAM
  bit            m_last_m1;    // who won most recently
  bit            m_rv0, m_rv1;
  logic [DW-1:0] m_rd0, m_rd1;
  bit            eg0, eg1;

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_owned = 0; m_last_m1 = 0; m_rv0 = 0; m_rv1 = 0;
    m_rd0 = '0; m_rd1 = '0;
    exp_q0.delete(); exp_q1.delete();
  endtask

  // Who gets the RAM this cycle, from the ownership rules
  task automatic model_grant();
    if (m_owned) begin
      eg0 = 0; eg1 = bus.m1_req;
    end else if (bus.m0_req && bus.m1_req) begin
      eg1 = RR ? !m_last_m1 : 1'b1;
      eg0 = !eg1;
    end else begin
      eg0 = bus.m0_req; eg1 = bus.m1_req;
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive_idle();
    bus.m0_req = 0; bus.m0_addr = '0;
    bus.m1_req = 0; bus.m1_we = 0; bus.m1_wem = '0; bus.m1_addr = '0;
    bus.m1_wdata = '0; bus.m1_lock = 0;
  endtask

  task automatic drive_m0(input bit req, input logic [AW-1:0] addr);
    bus.m0_req = req; bus.m0_addr = addr;
  endtask

  task automatic drive_m1(input bit req, input bit we, input logic [MW-1:0] wem,
                          input logic [AW-1:0] addr, input logic [DW-1:0] wdata, input bit lock);
    bus.m1_req = req; bus.m1_we = we; bus.m1_wem = wem;
    bus.m1_addr = addr; bus.m1_wdata = wdata; bus.m1_lock = lock;
  endtask

  // One clock: check comb outputs, advance model at the edge, check responses.
  // Entered and left just after a falling edge.
  task automatic cycle();
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_din;
    logic [MW-1:0] e_wem;
    bit            e_we;
    #1;
    model_grant();
    e_we   = eg1 && bus.m1_we;
    e_wem  = e_we ? bus.m1_wem : '0;
    e_addr = eg1 ? bus.m1_addr : (eg0 ? bus.m0_addr : '0);
    e_din  = eg1 ? bus.m1_wdata : '0;
    chk("m0_gnt",   bus.m0_gnt, eg0);
    chk("m1_gnt",   bus.m1_gnt, eg1);
    chk("ram_cs",   bus.ram_cs, eg0 | eg1);
    chk("ram_we",   bus.ram_we, e_we);
    chk("ram_wem",  bus.ram_wem, e_wem);
    chk("ram_addr", bus.ram_addr, e_addr);
    chk("ram_din",  bus.ram_din, e_din);
    @(posedge clk);
    if (eg0) exp_q0.push_back(ref_mem[bus.m0_addr[5:2]]);
    if (eg1 && !bus.m1_we) exp_q1.push_back(ref_mem[bus.m1_addr[5:2]]);
    if (eg1 && bus.m1_we)
      for (int b = 0; b < MW; b++)
        if (bus.m1_wem[b]) ref_mem[bus.m1_addr[5:2]][8*b +: 8] = bus.m1_wdata[8*b +: 8];
    m_rv0 = eg0;
    m_rv1 = eg1 && !bus.m1_we;
    if (m_owned) m_owned = bus.m1_req && bus.m1_lock;
    else         m_owned = eg1 && bus.m1_lock;
    if (eg1)      m_last_m1 = 1;
    else if (eg0) m_last_m1 = 0;
    @(negedge clk);
    if (m_rv0 && exp_q0.size() > 0) m_rd0 = exp_q0.pop_front();
    if (m_rv1 && exp_q1.size() > 0) m_rd1 = exp_q1.pop_front();
    chk("m0_rvalid", bus.m0_rvalid, m_rv0);
    chk("m1_rvalid", bus.m1_rvalid, m_rv1);
    chk("m0_rdata",  bus.m0_rdata, m_rd0);
    chk("m1_rdata",  bus.m1_rdata, m_rd1);
    chk("lock_state", dbg_lock, m_owned);
    chk("last_m1",    dbg_last_m1, m_last_m1);
  endtask

  // ---------------- directed + random sequence ----------------
  bit            p0, p1, p1_we, p1_lock;
  logic [AW-1:0] p0_addr, p1_addr;
  logic [MW-1:0] p1_wem;
  logic [DW-1:0] p1_wdata;

  initial begin
    rst_n = 0;
    drive_idle();
    for (int i = 0; i < 16; i++) begin
      ram_mem[i] = $urandom;
      ref_mem[i] = ram_mem[i];
    end
    model_reset();
    repeat (2) @(negedge clk);
    // reset state
    chk("rst_m0_rvalid", bus.m0_rvalid, 0);
    chk("rst_m1_rvalid", bus.m1_rvalid, 0);
    chk("rst_m0_rdata",  bus.m0_rdata, 0);
    chk("rst_m1_rdata",  bus.m1_rdata, 0);
    chk("rst_state",     dbg_lock, 0);
    chk("rst_last",      dbg_last_m1, 0);
    rst_n = 1;
    @(negedge clk);

    // IFU read of 0x10
    drive_m0(1, 32'h10);
    cycle();
    chk("m0_read_word", bus.m0_rdata, ref_mem[4]);
    drive_idle();

    // LSU half-word write then read back
    drive_m1(1, 1, 4'b0011, 32'h20, 32'hA5A5_1234, 0);
    cycle();
    chk("m1_wr_no_rvalid", bus.m1_rvalid, 0);
    drive_m1(1, 0, 4'b0000, 32'h20, '0, 0);
    cycle();
    chk("m1_rd_low_half", {16'h0, bus.m1_rdata[15:0]}, 32'h1234);
    drive_idle();

    // make m0 the last winner, then 4 cycles of conflict
    drive_m0(1, 32'h4);
    cycle();
    for (int i = 0; i < 4; i++) begin
      drive_m0(1, 32'(4 * i));
      drive_m1(1, 0, 4'b0000, 32'(4 * i + 32), '0, 0);
      #1;
      chk("conflict_m1_gnt", bus.m1_gnt, RR ? ((i % 2) == 0) : 1'b1);
      #1;
      cycle();
    end
    drive_idle();

    // lock: 3 LSU accesses with IFU waiting, lock dropped on the 3rd
    drive_m0(1, 32'h8);
    for (int i = 0; i < 3; i++) begin
      drive_m1(1, i[0], 4'b1111, 32'h30, $urandom, i < 2);
      #1;
      chk("lock_m0_blocked", bus.m0_gnt, 0);
      #1;
      cycle();
    end
    drive_m1(0, 0, '0, '0, '0, 0);
    #1;
    chk("lock_release_m0", bus.m0_gnt, 1);
    #1;
    cycle();
    drive_idle();

    // reset while m1_rvalid is high and LSU holds the lock
    drive_m1(1, 0, 4'b0000, 32'h24, '0, 1);
    cycle();
    chk("pre_rst_rvalid", bus.m1_rvalid, 1);
    drive_idle();
    rst_n = 0;
    #1;
    chk("mid_rst_m1_rvalid", bus.m1_rvalid, 0);
    chk("mid_rst_m1_rdata",  bus.m1_rdata, 0);
    chk("mid_rst_state",     dbg_lock, 0);
    model_reset();
    @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    drive_m0(1, 32'h0);
    drive_m1(1, 0, 4'b0000, 32'h3C, '0, 0);
    #1;
    chk("post_rst_conflict", bus.m1_gnt, 1);
    #1;
    cycle();
    drive_idle();

    // idle
    cycle();
    chk("idle_cs", bus.ram_cs, 0);
    cycle();
    chk("idle_rvalid", {bus.m0_rvalid, bus.m1_rvalid}, 0);

    // random traffic honouring hold-until-grant
    p0 = 0; p1 = 0;
    for (int n = 0; n < 500; n++) begin
      if (!p0 && $urandom_range(0, 2) != 0) begin
        p0 = 1; p0_addr = {$urandom_range(0, 15), 2'b00};
      end
      if (!p1 && $urandom_range(0, 2) != 0) begin
        p1 = 1; p1_we = $urandom_range(0, 1); p1_wem = $urandom;
        p1_addr = {$urandom_range(0, 15), 2'b00}; p1_wdata = $urandom;
        p1_lock = ($urandom_range(0, 3) == 0);
      end
      drive_m0(p0, p0 ? p0_addr : '0);
      drive_m1(p1, p1_we, p1_wem, p1 ? p1_addr : '0, p1_wdata, p1 && p1_lock);
      cycle();
      if (eg0) p0 = 0;
      if (eg1) p1 = 0;
    end
    drive_idle();
    cycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/ram_port_arbiter.md
# ram_port_arbiter

Two-port arbiter and sequencer for the shared single-port general SRAM (`gnrl_ram`). It sits between the instruction-fetch port (master 0, read-only) and the load/store port (master 1, read/write) and drives one RAM access per cycle. It registers read data so each master sees a clean one-cycle response. A lock input lets the LSU hold the RAM for back-to-back accesses, such as read-modify-write of sub-word stores.

## Interface
- AW, 32, address width, passed through unmodified
- DW, 32, data width
- MW, 4, byte write-enable width (DW/8)
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- m0_req  in  1  IFU read request
- m0_addr  in  AW  IFU byte address
- m0_gnt  out  1  IFU request accepted this cycle
- m0_rvalid  out  1  IFU read data valid
- m0_rdata  out  DW  IFU read data
- m1_req  in  1  LSU request
- m1_we  in  1  LSU write (1) / read (0)
- m1_wem  in  MW  LSU byte enables, used only when m1_we=1
- m1_addr  in  AW  LSU byte address
- m1_wdata  in  DW  LSU write data
- m1_lock  in  1  LSU requests to keep ownership after this access
- m1_gnt  out  1  LSU request accepted this cycle
- m1_rvalid  out  1  LSU read data valid
- m1_rdata  out  DW  LSU read data
- ram_cs, ram_we  out  1  RAM chip select / write
- ram_wem  out  MW  RAM byte enables
- ram_addr  out  AW  RAM address
- ram_din  out  DW  RAM write data
- ram_dout  in  DW  RAM combinational read data

## Operation
- Grants are combinational from the request inputs and the state. At most one grant is active per cycle. A grant is never given without a request.
- The granted master's address, write enable, byte enables, and data drive the RAM port directly. With no grant: ram_cs=0, ram_we=0, ram_wem=0, ram_addr=0, ram_din=0.
- Master 0 always drives ram_we=0 and ram_wem=0.
- Read accepted (gnt & ~we): ram_dout is captured into that master's rdata register at the same edge. That master's rvalid is 1 for exactly the next cycle. rdata holds its value until the next read for that master completes.
- Write accepted: the RAM writes at the same edge. No rvalid is produced and rdata is unchanged.
- FSM with two states:
  - ARB: normal arbitration (see Configuration). If m1 is granted and m1_lock=1, go to LOCK.
  - LOCK: m1 is the only eligible master and m0_gnt=0. Stay in LOCK while m1_req & m1_lock. Return to ARB on a cycle with m1_req=0, or on a granted access with m1_lock=0.
- A last-grant pointer (last_m1) updates on every grant. It records whether m1 (1) or m0 (0) was last granted.

## Timing
- Reset values (asynchronous): state=ARB, last_m1=0, m0_rvalid=0, m1_rvalid=0, m0_rdata=0, m1_rdata=0.
- Request to grant: 0 cycles.
- Grant to rvalid: 1 cycle.
- Throughput: one access per cycle. Back-to-back reads from the same master produce rvalid on consecutive cycles.
- Requesters hold req, addr, and data stable until gnt is sampled high.
- Simultaneous request from both masters in ARB: the winner is set by the policy in Configuration. The loser sees gnt=0 and retries.
- Reset asserted mid-operation: rvalid and rdata clear immediately and state returns to ARB. A RAM write on the edge coincident with reset assertion is not guaranteed.

## Configuration
- ARB_ROUND_ROBIN_EN defined:
  - On a conflict in ARB, the master not last granted wins. With last_m1=0, m1 wins; with last_m1=1, m0 wins.
  - A sole requester always wins.
- ARB_ROUND_ROBIN_EN undefined:
  - Fixed priority: m1 always wins a conflict.
  - last_m1 is still maintained but not used.

## Test plan
- After reset, m0_req=1 with m0_addr=0x10 → m0_gnt=1, ram_cs=1, ram_we=0, ram_addr=0x10. Next cycle m0_rvalid=1 and m0_rdata equals the RAM word.
- m1 write with addr=0x20, wdata=0xA5A5_1234, wem=4'b0011 → m1_gnt=1, ram_we=1, ram_wem=4'b0011. m1_rvalid stays 0. A following m1 read of 0x20 → m1_rdata low halfword = 0x1234.
- Both masters request for 4 cycles with ARB_ROUND_ROBIN_EN defined → grants go m1, m0, m1, m0. With the macro undefined → m1 for all 4 cycles.
- m1_lock=1 for 3 accesses while m0_req=1 → m0_gnt=0 for all 3 cycles. m1 drops lock on its 3rd access → m0 is granted on the next cycle.
- rst_n pulsed low while m1_rvalid=1 → m1_rvalid=0 and m1_rdata=0 immediately, state=ARB. The first conflict after reset goes to m1.
- No requests → ram_cs=0, both gnt=0, and both rvalid=0 on the following cycle.
